// File: rtl/uc_arbiter.sv
// uc_arbiter: round-robin unit-literal serialiser, broadcasts to all engine UCQ_out queues.
// UCARB_DUP_FILTER_EN adds a broadcast history that drops duplicates and halts on a complementary literal.
module uc_arbiter #(
  parameter int N_ENG      = 4,
  parameter int LIT_W      = 11,
  parameter int HIST_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LIT_W-1:0]       host_uc,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [N_ENG-1:0]       UCQ_in_empty,
  input  logic [N_ENG*LIT_W-1:0] UCQ_in2uarb_uc,
  output logic [N_ENG-1:0]       ucarb2UCQ_in_pop,
  input  logic [N_ENG-1:0]       UCQ_out_full,
  output logic [LIT_W-1:0]       ucarb2UCQ_out_uc,
  output logic [N_ENG-1:0]       ucarb2UCQ_out_push,
  output logic                   idle,
  output logic                   conflict,
  output logic [CNT_W-1:0]       bcast_cnt
);
  localparam int PW = N_ENG > 1 ? $clog2(N_ENG) : 1;
  typedef enum logic [1:0] {SEL, BCAST, HALT} state_t;
  state_t state, state_n;
  logic [LIT_W-1:0] hold, hold_n;
  logic [PW-1:0] rr, rr_n;
  logic [N_ENG-1:0] pop;
  logic push, dup, neg, conflict_n, grab, sel_host, sel_idle;
  if (HIST_DEPTH < 1) begin : g_bad_depth
    $error("HIST_DEPTH must be at least 1");
  end
`ifdef UCARB_DUP_FILTER_EN
  logic [LIT_W-1:0] hist [HIST_DEPTH];
  logic [LIT_W-1:0] neg_hold;
  assign neg_hold = '0 - hold;
  // Cleared entries are 0 and a non-null hold can never match them.
  always_comb begin
    dup = 1'b0;
    neg = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      dup = dup | (hist[i] == hold);
      neg = neg | (hist[i] == neg_hold);
    end
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    else if (push) begin
      hist[0] <= hold;
      for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
    end
`else
  assign dup = 1'b0;
  assign neg = 1'b0;
`endif
  always_comb begin
    state_n    = state;
    hold_n     = hold;
    rr_n       = rr;
    pop        = '0;
    push       = 1'b0;
    conflict_n = conflict;
    grab       = 1'b0;
    sel_host   = 1'b0;
    sel_idle   = 1'b0;
    if (state == SEL) begin
      if (host_valid) begin
        sel_host = 1'b1;
        hold_n   = host_uc;
        state_n  = BCAST;
      end else begin
        for (int k = 0; k < N_ENG; k++)
          for (int i = 0; i < N_ENG; i++)
            if (!grab && i == (int'(rr) + k) % N_ENG && !UCQ_in_empty[i]) begin
              grab    = 1'b1;
              pop[i]  = 1'b1;
              hold_n  = UCQ_in2uarb_uc[i*LIT_W +: LIT_W];
              rr_n    = PW'((i + 1) % N_ENG);
              state_n = BCAST;
            end
        sel_idle = !grab;
      end
    end else if (state == BCAST) begin
      if (hold == '0 || dup) state_n = SEL;
      else if (neg) begin
        conflict_n = 1'b1;
        state_n    = HALT;
      end else if (UCQ_out_full == '0) begin
        push    = 1'b1;
        state_n = SEL;
      end
    end
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      state     <= SEL;
      hold      <= '0;
      rr        <= '0;
      conflict  <= 1'b0;
      bcast_cnt <= '0;
    end else begin
      state    <= state_n;
      hold     <= hold_n;
      rr       <= rr_n;
      conflict <= conflict_n;
      if (push) bcast_cnt <= bcast_cnt + 1'b1;
    end
  // Combinational strobes are forced low while reset is held.
  assign host_ready         = !rst_n && sel_host;
  assign idle               = !rst_n && sel_idle;
  assign ucarb2UCQ_in_pop   = rst_n ? '0 : pop;
  assign ucarb2UCQ_out_push = {N_ENG{push && !rst_n}};
  assign ucarb2UCQ_out_uc   = (push && !rst_n) ? hold : '0;
endmodule

// File: tb/tb_uc_arbiter.sv
// tb_uc_arbiter: randomized + directed bench for uc_arbiter against a queue-based reference model.
module tb_uc_arbiter;
  localparam int N = 4, LW = 11, HD = 8, CW = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [LW-1:0] host_uc = '0;
  logic host_valid = 1'b0, host_ready, idle, conflict;
  logic [N-1:0] UCQ_in_empty = '1, UCQ_out_full = '0, pop, push;
  logic [N*LW-1:0] heads = '0;
  logic [LW-1:0] uc;
  logic [CW-1:0] bcast_cnt;
  int n_chk = 0, n_fail = 0;
  logic [LW-1:0] q [N][$];
  logic [LW-1:0] hist [$];
  logic [LW-1:0] dut_log [$];
  logic m_busy = 0, m_halt = 0, m_conf = 0;
  logic [LW-1:0] m_pend = '0;
  logic [CW-1:0] m_cnt = '0;
  int m_rr = 0;

  uc_arbiter #(.N_ENG(N), .LIT_W(LW), .HIST_DEPTH(HD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .host_uc(host_uc), .host_valid(host_valid), .host_ready(host_ready),
    .UCQ_in_empty(UCQ_in_empty), .UCQ_in2uarb_uc(heads), .ucarb2UCQ_in_pop(pop),
    .UCQ_out_full(UCQ_out_full), .ucarb2UCQ_out_uc(uc), .ucarb2UCQ_out_push(push),
    .idle(idle), .conflict(conflict), .bcast_cnt(bcast_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_heads();
    for (int i = 0; i < N; i++) begin
      UCQ_in_empty[i] = q[i].size() == 0;
      heads[i*LW +: LW] = q[i].size() != 0 ? q[i][0] : '0;
    end
  endtask

  // One clock: drive, predict, compare, then advance the model past the edge.
  task automatic step(input logic hv, input logic [LW-1:0] hu, input logic [N-1:0] fl);
    logic [N-1:0] ep;
    logic eh, ei, epsh, grab, hit_dup, hit_neg;
    logic [LW-1:0] nxt, negp;
    int ge;
    host_valid = hv;
    host_uc = hu;
    UCQ_out_full = fl;
    drive_heads();
    #2;
    ep = '0; eh = 0; ei = 0; epsh = 0; grab = 0; hit_dup = 0; hit_neg = 0; nxt = '0; ge = -1;
    negp = '0 - m_pend;
    if (!m_halt && !m_busy) begin
      if (hv) begin
        eh = 1; grab = 1; nxt = hu;
      end else
        for (int k = 0; k < N && !grab; k++)
          if (q[(m_rr + k) % N].size() != 0) begin
            ge = (m_rr + k) % N; grab = 1; ep[ge] = 1; nxt = q[ge][0];
          end
      ei = !grab;
    end else if (m_busy && m_pend != 0) begin
`ifdef UCARB_DUP_FILTER_EN
      foreach (hist[j]) begin
        hit_dup |= hist[j] == m_pend;
        hit_neg |= hist[j] == negp;
      end
`endif
      epsh = !hit_dup && !hit_neg && fl == '0;
    end
    check("pop", pop, ep);
    check("host_ready", host_ready, eh);
    check("idle", idle, ei);
    check("push", push, {N{epsh}});
    check("uc", uc, epsh ? m_pend : '0);
    check("conflict", conflict, m_conf);
    check("bcast_cnt", bcast_cnt, m_cnt);
    if (push[0]) dut_log.push_back(uc);
    @(posedge clk);
    #1;
    if (ge >= 0) void'(q[ge].pop_front());
    if (m_busy) begin
      if (epsh) begin
        m_cnt++;
        hist.push_back(m_pend);
        if (hist.size() > HD) void'(hist.pop_front());
      end
      if (m_pend == 0 || hit_dup || epsh) m_busy = 0;
      else if (hit_neg && !hit_dup) begin
        m_busy = 0; m_halt = 1; m_conf = 1;
      end
    end else if (grab) begin
      m_busy = 1;
      m_pend = nxt;
      if (ge >= 0) m_rr = (ge + 1) % N;
    end
  endtask

  task automatic do_reset();
    host_valid = 1'b1;
    host_uc = 11'h123;
    drive_heads();
    rst_n = 1'b1;
    #1;
    check("rst_pop", pop, 0);
    check("rst_host_ready", host_ready, 0);
    check("rst_idle", idle, 0);
    check("rst_push", push, 0);
    check("rst_uc", uc, 0);
    check("rst_conflict", conflict, 0);
    check("rst_cnt", bcast_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    host_valid = 1'b0;
    m_busy = 0; m_halt = 0; m_conf = 0; m_rr = 0; m_cnt = '0;
    hist.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0);
  endtask

  initial begin
    #6;
    do_reset();
    // host injection
    step(1, 11'h7FF, '0);
    step(0, '0, '0);
    check("t2_cnt", bcast_cnt, 1);
    check("t2_lit", dut_log.size() == 1 ? dut_log[0] : '1, 11'h7FF);
    // round robin over four full engines
    q[0].push_back(3); q[1].push_back(5); q[2].push_back(6); q[3].push_back(9);
    run(9);
    check("t3_n", dut_log.size(), 5);
    if (dut_log.size() == 5) begin
      check("t3_0", dut_log[1], 3); check("t3_1", dut_log[2], 5);
      check("t3_2", dut_log[3], 6); check("t3_3", dut_log[4], 9);
    end
    // back-pressure holds the literal
    q[1].push_back(12);
    step(0, '0, '0);
    repeat (5) step(0, '0, 4'b0100);
    step(0, '0, '0);
    check("t4_lit", dut_log[$], 12);
    check("t4_cnt", bcast_cnt, 6);
    // null literal is dropped
    q[2].push_back(0); q[3].push_back(4);
    run(2);
    check("t5_cnt", bcast_cnt, 6);
    run(3);
    check("t5_lit", dut_log[$], 4);
    // reset while stalled in broadcast discards the held literal
    q[0].push_back(21);
    step(0, '0, '0);
    step(0, '0, 4'b1000);
    UCQ_out_full = 4'b1000;
    do_reset();
    run(3);
    check("t1_cnt", bcast_cnt, 0);
    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() < 4 && $urandom_range(0, 3) == 0) q[i].push_back(LW'($urandom_range(0, 40)));
      step($urandom_range(0, 7) == 0, LW'($urandom_range(0, 2047)),
           $urandom_range(0, 3) == 0 ? N'($urandom_range(1, 15)) : '0);
    end
    for (int i = 0; i < N; i++) q[i].delete();
    run(2);
`ifdef UCARB_DUP_FILTER_EN
    do_reset();
    q[0].push_back(3);
    run(2);
    q[0].push_back(3);
    run(2);
    check("t6_dup_cnt", bcast_cnt, 1);
    q[0].push_back(11'h7FD);
    run(2);
    check("t6_conflict", conflict, 1);
    q[1].push_back(8); q[2].push_back(10);
    run(4);
    check("t6_halt_cnt", bcast_cnt, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
